// File: rtl/sonic_constants.sv
// Shared types and widths for the SONIC transmit/MSI arbitration slice.
package sonic_constants;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_OWNED = 2'd2
  } arb_state_t;

  localparam int MSI_NUM_WIDTH = 5;
  localparam int TCNT_W        = 16;

endpackage

// File: rtl/sonic_rr_arbiter.sv
// Round-robin grant FSM for one shared channel: IDLE -> GRANT -> OWNED,
// with an optional watchdog that revokes a grant the client never takes up.
module sonic_rr_arbiter
  import sonic_constants::*;
#(
  parameter int  NUM_CLIENTS   = 4,
  parameter int  GRANT_TIMEOUT = 64,
  localparam int IDX_W         = $clog2(NUM_CLIENTS)
) (
  input  logic                   clk_in,
  input  logic                   rstn,
  input  logic [NUM_CLIENTS-1:0] ready,
  input  logic [NUM_CLIENTS-1:0] busy,
  output logic [NUM_CLIENTS-1:0] sel,
  output logic [IDX_W-1:0]       winner,
  output logic [1:0]             state,
  output logic                   timeout_pulse
);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       win_q, win_d, pick_s, idx_s;
  logic [NUM_CLIENTS-1:0] sel_q, sel_d;
  logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
  logic                   found_s, timeout_s;

  // The winner register doubles as the round-robin pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = win_q;
    idx_s   = win_q;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      idx_s = IDX_W'((int'(win_q) + k) % NUM_CLIENTS);
      if (!found_s && ready[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    sel_d     = sel_q;
    tcnt_d    = tcnt_q;
    timeout_s = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        sel_d = '0;
        if (found_s) begin
          state_d       = ARB_GRANT;
          win_d         = pick_s;
          sel_d[pick_s] = 1'b1;
          tcnt_d        = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        // busy takes precedence over a simultaneous ready drop
        if (busy[win_q]) begin
          state_d = ARB_OWNED;
        end else if (!ready[win_q]) begin
          state_d = ARB_IDLE;
          sel_d   = '0;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
          if ((GRANT_TIMEOUT != 0) && (int'(tcnt_d) == GRANT_TIMEOUT)) begin
            state_d   = ARB_IDLE;
            sel_d     = '0;
            timeout_s = 1'b1;
          end else begin
            state_d = ARB_GRANT;
          end
        end
      end
      ARB_OWNED: begin
        if (!busy[win_q]) begin
          state_d = ARB_IDLE;
          sel_d   = '0;
        end else begin
          state_d = ARB_OWNED;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      win_q   <= IDX_W'(NUM_CLIENTS - 1);
      sel_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign sel           = sel_q;
  assign winner        = win_q;
  assign state         = state_q;
  assign timeout_pulse = timeout_s;

endmodule

// File: rtl/sonic_tx_msi_arbiter.sv
// Shares the PCIe core TX port and MSI request port among NUM_CLIENTS clients:
// two round-robin arbiters, the granted-client muxes and per-client ack routing.
module sonic_tx_msi_arbiter
  import sonic_constants::*;
#(
  parameter int NUM_CLIENTS   = 4,
  parameter int IDX_W         = $clog2(NUM_CLIENTS),
  parameter int GRANT_TIMEOUT = 64,
  parameter int MSI_NUM_BASE  = 0
) (
  input  logic                         clk_in,
  input  logic                         rstn,
  input  logic [NUM_CLIENTS-1:0]       tx_ready,
  input  logic [NUM_CLIENTS-1:0]       tx_busy,
  output logic [NUM_CLIENTS-1:0]       tx_sel,
  output logic [NUM_CLIENTS-1:0]       tx_ready_others,
  input  logic [NUM_CLIENTS-1:0]       c_tx_req,
  input  logic [NUM_CLIENTS*128-1:0]   c_tx_desc,
  input  logic [NUM_CLIENTS-1:0]       c_tx_dv,
  input  logic [NUM_CLIENTS-1:0]       c_tx_dfr,
  input  logic [NUM_CLIENTS*128-1:0]   c_tx_data,
  input  logic [NUM_CLIENTS-1:0]       c_tx_err,
  output logic [NUM_CLIENTS-1:0]       c_tx_ack,
  output logic [NUM_CLIENTS-1:0]       c_tx_ws,
  output logic                         tx_req,
  output logic [127:0]                 tx_desc,
  output logic                         tx_dv,
  output logic                         tx_dfr,
  output logic [127:0]                 tx_data,
  output logic                         tx_err,
  input  logic                         tx_ack,
  input  logic                         tx_ws,
  input  logic [NUM_CLIENTS-1:0]       msi_ready,
  input  logic [NUM_CLIENTS-1:0]       msi_busy,
  input  logic [NUM_CLIENTS-1:0]       c_app_msi_req,
  output logic [NUM_CLIENTS-1:0]       msi_sel,
  output logic [NUM_CLIENTS-1:0]       c_app_msi_ack,
  output logic                         app_msi_req,
  output logic [MSI_NUM_WIDTH-1:0]     app_msi_num,
  input  logic                         app_msi_ack,
  output logic [15:0]                  arb_timeout_cnt
);

  logic [IDX_W-1:0]       tx_win_s, msi_win_s;
  logic [1:0]             tx_state_s, msi_state_s;
  logic                   tx_to_s, msi_to_s, tx_act_s, msi_own_s;
  logic [NUM_CLIENTS-1:0] mask_s;
  logic [16:0]            to_sum_s;
  logic [15:0]            to_cnt_q, to_cnt_d;

  sonic_rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS), .GRANT_TIMEOUT(GRANT_TIMEOUT)) u_tx_arb (
    .clk_in(clk_in), .rstn(rstn), .ready(tx_ready), .busy(tx_busy),
    .sel(tx_sel), .winner(tx_win_s), .state(tx_state_s), .timeout_pulse(tx_to_s)
  );

  sonic_rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS), .GRANT_TIMEOUT(GRANT_TIMEOUT)) u_msi_arb (
    .clk_in(clk_in), .rstn(rstn), .ready(msi_ready), .busy(msi_busy),
    .sel(msi_sel), .winner(msi_win_s), .state(msi_state_s), .timeout_pulse(msi_to_s)
  );

  assign tx_act_s  = (tx_state_s == ARB_GRANT) || (tx_state_s == ARB_OWNED);
  assign msi_own_s = (msi_state_s == ARB_OWNED);

  // The core sees the winner's TX lanes with no added latency, zeros otherwise.
  always_comb begin
    tx_req  = 1'b0;
    tx_desc = '0;
    tx_dv   = 1'b0;
    tx_dfr  = 1'b0;
    tx_data = '0;
    tx_err  = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (tx_act_s && (tx_win_s == IDX_W'(i))) begin
        tx_req  = c_tx_req[i];
        tx_desc = c_tx_desc[i*128 +: 128];
        tx_dv   = c_tx_dv[i];
        tx_dfr  = c_tx_dfr[i];
        tx_data = c_tx_data[i*128 +: 128];
        tx_err  = c_tx_err[i];
      end else begin
        tx_req = tx_req;
      end
    end
  end

  always_comb begin
    tx_ready_others = '0;
    mask_s          = '1;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      mask_s             = '1;
      mask_s[i]          = 1'b0;
      tx_ready_others[i] = |(tx_busy & mask_s);
    end
  end

  assign c_tx_ack      = {NUM_CLIENTS{tx_ack}} & tx_sel;
  assign c_tx_ws       = {NUM_CLIENTS{tx_ws}};
  assign c_app_msi_ack = {NUM_CLIENTS{app_msi_ack}} & msi_sel;
  assign app_msi_req   = msi_own_s & c_app_msi_req[msi_win_s];
  assign app_msi_num   = msi_own_s ? MSI_NUM_WIDTH'(MSI_NUM_BASE + int'(msi_win_s))
                                   : {MSI_NUM_WIDTH{1'b0}};

  // Both channels can revoke in the same cycle, so add both before saturating.
  always_comb begin
    to_sum_s = {1'b0, to_cnt_q} + {16'd0, tx_to_s} + {16'd0, msi_to_s};
    if (to_sum_s[16]) begin
      to_cnt_d = 16'hFFFF;
    end else begin
      to_cnt_d = to_sum_s[15:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      to_cnt_q <= 16'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign arb_timeout_cnt = to_cnt_q;

endmodule

// File: doc/sonic_tx_msi_arbiter.md
Name: sonic_tx_msi_arbiter

Overview:
- Arbitrates the PCIe backend transmit port and the MSI request port among NUM_CLIENTS DMA/IRQ clients. Clients include the per-port IRQ generators, the command/status RC updaters and the RX/TX DMA engines.
- Consumes each client's tx_ready/tx_busy and msi_ready/msi_busy, and returns tx_sel/msi_sel/tx_ready_others.
- Muxes the granted client's TX signals and MSI request onto the single PCIe core interface, and routes the core's acks back to that client only.

Parameters:
- NUM_CLIENTS, 4, number of clients (2..8).
- IDX_W, $clog2(NUM_CLIENTS), client index width.
- GRANT_TIMEOUT, 64, cycles a grant may sit without busy before it is revoked; 0 disables.
- MSI_NUM_BASE, 0, 5-bit MSI vector number for client 0; client i uses MSI_NUM_BASE+i.

Ports:
- clk_in in 1: clock.
- rstn in 1: reset, synchronous, active-low.
- tx_ready in NUM_CLIENTS: client i wants the TX bus.
- tx_busy in NUM_CLIENTS: client i holds the TX bus.
- tx_sel out NUM_CLIENTS: one-hot TX grant.
- tx_ready_others out NUM_CLIENTS: bit i = OR of tx_busy[j] for all j != i.
- c_tx_req in NUM_CLIENTS: per-client tx_req.
- c_tx_desc in NUM_CLIENTS*128: per-client tx_desc.
- c_tx_dv in NUM_CLIENTS: per-client tx_dv.
- c_tx_dfr in NUM_CLIENTS: per-client tx_dfr.
- c_tx_data in NUM_CLIENTS*128: per-client tx_data.
- c_tx_err in NUM_CLIENTS: per-client tx_err.
- c_tx_ack out NUM_CLIENTS: core tx_ack routed to the granted client.
- tx_req out 1, tx_desc out 128, tx_dv out 1, tx_dfr out 1, tx_data out 128, tx_err out 1: to the PCIe core.
- tx_ack in 1, tx_ws in 1: from the core; tx_ws is broadcast unchanged to all clients.
- msi_ready in NUM_CLIENTS, msi_busy in NUM_CLIENTS, c_app_msi_req in NUM_CLIENTS: MSI side of each client.
- msi_sel out NUM_CLIENTS: one-hot MSI grant.
- c_app_msi_ack out NUM_CLIENTS: core MSI ack routed to the granted client.
- app_msi_req out 1, app_msi_num out 5: to the core.
- app_msi_ack in 1: from the core.
- arb_timeout_cnt out 16: saturating count of revoked grants, both channels.

Behaviour:
- Channels: two independent channels (TX, MSI), each run by an identical round-robin FSM with states ARB_IDLE, ARB_GRANT, ARB_OWNED.
- ARB_IDLE:
  - If any ready bit is set, pick the first set bit searching upward from (last+1) mod NUM_CLIENTS.
  - Register the winner index, set last = winner, assert sel one-hot next cycle, go to ARB_GRANT.
  - Latency from ready to sel is 1 cycle.
- ARB_GRANT:
  - busy[winner]=1 -> ARB_OWNED.
  - Else ready[winner]=0 (client init/abort) -> ARB_IDLE, sel cleared.
  - Else timeout counter reaches GRANT_TIMEOUT (when nonzero) -> ARB_IDLE, sel cleared, arb_timeout_cnt increments.
- ARB_OWNED:
  - sel is held.
  - busy[winner] falling -> ARB_IDLE, sel cleared.
  - No timeout applies in this state.
- Minimum 1-cycle IDLE bubble between grants. Granting the same client back-to-back is allowed only when it is the sole requester.
- Simultaneous busy and ready drop in ARB_GRANT: busy wins.
- TX mux (combinational, no added latency): outputs are the c_tx_* of the winner while TX state is GRANT or OWNED; otherwise tx_req/tx_dv/tx_dfr/tx_err = 0 and tx_desc/tx_data = 0.
- tx_ack routing: c_tx_ack[i] = tx_ack & tx_sel[i].
- tx_ready_others: purely combinational from tx_busy.
- MSI mux:
  - app_msi_req = c_app_msi_req[winner] while MSI state is OWNED, else 0.
  - app_msi_num = MSI_NUM_BASE + winner, held while OWNED, else 0.
  - c_app_msi_ack[i] = app_msi_ack & msi_sel[i].
- Reset (rstn=0 at clk_in edge):
  - Both FSMs go to ARB_IDLE; sel = 0, last = NUM_CLIENTS-1 so client 0 wins first.
  - Timeout counters = 0, arb_timeout_cnt = 0, all muxed outputs 0.
  - A reset mid-transfer drops the grant immediately; the core sees tx_dv=0 from the next cycle.
- Arithmetic:
  - Round-robin index wraps mod NUM_CLIENTS.
  - Timeout counter is 16 bits, cleared on every entry to ARB_GRANT.
  - arb_timeout_cnt saturates at 16'hFFFF.

Decomposition:
- sonic_constants.sv gets arb_state_t (ARB_IDLE=0, ARB_GRANT=1, ARB_OWNED=2) and `MSI_NUM_WIDTH = 5`.
- Sub-module sonic_rr_arbiter:
  - Contains the FSM, round-robin pointer and timeout logic.
  - Parameters: NUM_CLIENTS, GRANT_TIMEOUT.
  - Ports: ready, busy, sel, winner, state, timeout_pulse.
  - Instantiated twice, once for TX and once for MSI.
- The top level holds the muxes, ack routing, tx_ready_others and the saturating counter.

Test Plan:
- Single client: tx_ready[2]=1 at cycle 0 -> tx_sel=4'b0100 at cycle 1; tx_busy[2]=1 for 5 cycles -> tx_req/tx_desc/tx_data follow client 2; tx_busy falls -> tx_sel=0 next cycle.
- Fairness: all four tx_ready held high and each grant completed in 3 cycles -> grant order 0,1,2,3,0; each grant separated by exactly 1 idle cycle.
- Timeout: tx_ready[1]=1, busy never rises, GRANT_TIMEOUT=64 -> tx_sel[1] drops after cycle 64 of grant; arb_timeout_cnt=1; client 2 requesting is granted next.
- MSI: msi_ready[3]=1, msi_busy[3]=1, c_app_msi_req[3]=1, MSI_NUM_BASE=4 -> app_msi_req=1, app_msi_num=7; app_msi_ack pulse -> c_app_msi_ack=4'b1000 only.
- Isolation: tx_ack asserted while client 1 owns -> c_tx_ack=4'b0010; tx_ready_others[0]=1 while tx_busy[1]=1, tx_ready_others[1]=0.
- Reset mid-OWNED: rstn=0 during tx_dv=1 -> tx_dv=0, tx_sel=0, msi_sel=0 next cycle; after release, client 0 wins first.
